// File: rtl/shift_reg_ctrl.sv
// Command sequencer for a single shift_reg: accepts LOAD/WRITE/DRAIN commands,
// streams words in and out with valid/ready handshakes and tracks the fill level.
module shift_reg_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int LENGTH     = 4,
  localparam int LW        = $clog2(LENGTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [LW-1:0]         cmd_len,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [1:0]            sr_ctrl_code,
  output logic [DATA_WIDTH-1:0] sr_data_write,
  input  logic [DATA_WIDTH-1:0] sr_data_read,
  output logic [LW-1:0]         level,
  output logic                  busy,
  output logic                  done,
  output logic                  clamp_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    WRITE = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic [LW-1:0] LEN_MAX = LW'(LENGTH);
  localparam logic [LW-1:0] ONE     = LW'(1);

  localparam logic [1:0] OP_LOAD  = 2'b01;
  localparam logic [1:0] OP_WRITE = 2'b10;
  localparam logic [1:0] OP_DRAIN = 2'b11;

  localparam logic [1:0] SR_HOLD  = 2'b00;
  localparam logic [1:0] SR_LOAD  = 2'b01;
  localparam logic [1:0] SR_SHIN  = 2'b10;
  localparam logic [1:0] SR_SHOUT = 2'b11;

  state_t        state;
  logic [LW-1:0] remaining;
  logic [LW-1:0] room;
  logic [LW-1:0] write_n;
  logic [LW-1:0] drain_n;
  logic          cmd_fire;

  // Saturate a requested word count to what the register can actually supply/absorb.
  function automatic logic [LW-1:0] clamp_len(input logic [LW-1:0] req,
                                               input logic [LW-1:0] avail);
    return (req > avail) ? avail : req;
  endfunction

  assign cmd_ready     = (state == IDLE);
  assign in_ready      = (state == WRITE);
  assign out_valid     = (state == DRAIN);
  assign busy          = (state != IDLE);
  assign out_data      = sr_data_read;
  assign sr_data_write = in_data;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign room     = LEN_MAX - level;
  assign write_n  = clamp_len(cmd_len, room);
  assign drain_n  = clamp_len(cmd_len, level);

  // Shift commands follow the handshake of the current cycle so a stalled word stays put.
  always_comb begin
    sr_ctrl_code = SR_HOLD;
    case (state)
      LOAD:    sr_ctrl_code = SR_LOAD;
      WRITE:   sr_ctrl_code = in_valid  ? SR_SHIN  : SR_HOLD;
      DRAIN:   sr_ctrl_code = out_ready ? SR_SHOUT : SR_HOLD;
      default: sr_ctrl_code = SR_HOLD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      level     <= '0;
      remaining <= '0;
      done      <= 1'b0;
      clamp_err <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_fire) begin
            case (cmd_op)
              OP_LOAD: state <= LOAD;
              OP_WRITE: begin
                remaining <= write_n;
                if (write_n != cmd_len) clamp_err <= 1'b1;
                if (write_n == '0) done  <= 1'b1;
                else               state <= WRITE;
              end
              OP_DRAIN: begin
                remaining <= drain_n;
                if (drain_n != cmd_len) clamp_err <= 1'b1;
                if (drain_n == '0) done  <= 1'b1;
                else               state <= DRAIN;
              end
              default: done <= 1'b1;
            endcase
          end
        end
        LOAD: begin
          level <= LEN_MAX;
          state <= IDLE;
          done  <= 1'b1;
        end
        WRITE: begin
          if (in_valid) begin
            level     <= level + ONE;
            remaining <= remaining - ONE;
            if (remaining == ONE) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        DRAIN: begin
          if (out_ready) begin
            level     <= level - ONE;
            remaining <= remaining - ONE;
            if (remaining == ONE) begin
              state <= IDLE;
              done  <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_reg_ctrl.sv
// Bench for shift_reg_ctrl: a queue-based shift_reg stand-in plus a transaction-level
// model of contents, level and clamp status; directed scenarios then random commands.
module tb_shift_reg_ctrl;
  localparam int DW  = 8;
  localparam int LEN = 4;
  localparam int LW  = $clog2(LEN + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [LW-1:0] cmd_len;
  logic          in_valid, in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid, out_ready;
  logic [DW-1:0] out_data;
  logic [1:0]    sr_ctrl_code;
  logic [DW-1:0] sr_data_write, sr_data_read;
  logic [LW-1:0] level;
  logic          busy, done, clamp_err;

  shift_reg_ctrl #(.DATA_WIDTH(DW), .LENGTH(LEN)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_len(cmd_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sr_ctrl_code(sr_ctrl_code), .sr_data_write(sr_data_write), .sr_data_read(sr_data_read),
    .level(level), .busy(busy), .done(done), .clamp_err(clamp_err)
  );

  always #5 clk = ~clk;

  // Stand-in shift_reg: head at mem[0], words enter behind the last held one.
  logic [DW-1:0] mem [LEN];
  logic [DW-1:0] load_vals [LEN];
  int            sr_cnt;

  always @(posedge clk) begin
    if (reset) begin
      sr_cnt <= 0;
    end else begin
      case (sr_ctrl_code)
        2'b01: begin
          for (int i = 0; i < LEN; i++) mem[i] <= load_vals[i];
          sr_cnt <= LEN;
        end
        2'b10: begin
          if (sr_cnt < LEN) begin
            mem[sr_cnt] <= sr_data_write;
            sr_cnt      <= sr_cnt + 1;
          end
        end
        2'b11: begin
          for (int i = 0; i < LEN - 1; i++) mem[i] <= mem[i+1];
          if (sr_cnt > 0) sr_cnt <= sr_cnt - 1;
        end
        default: ;
      endcase
    end
  end

  assign sr_data_read = mem[0];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: words that should be held, in order, and the sticky clamp flag.
  logic [DW-1:0] exp_q [$];
  int            lvl;
  bit            clamp_m;

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_cmd_ready"}, int'(cmd_ready), 1);
    chk({tag, "_in_ready"},  int'(in_ready), 0);
    chk({tag, "_out_valid"}, int'(out_valid), 0);
    chk({tag, "_ctrl"},      int'(sr_ctrl_code), 0);
    chk({tag, "_busy"},      int'(busy), 0);
    chk({tag, "_done"},      int'(done), 0);
    chk({tag, "_level"},     int'(level), 0);
    chk({tag, "_clamp"},     int'(clamp_err), 0);
  endtask

  // One command end to end. pat (LSB first) forces the in_valid/out_ready sequence when
  // use_pat is set; otherwise handshakes are random with probability vpct percent.
  // abort >= 0 asserts reset once that many words have moved.
  task automatic do_cmd(input int op, input int len, input bit use_pat,
                        input logic [7:0] pat, input int vpct, input int abort);
    int n, cnt, cyc;
    bit want;
    chk("cmd_ready_idle", int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_len   = LW'(len);
    n = 0;
    if (op == 2) n = (len < LEN - lvl) ? len : LEN - lvl;
    if (op == 3) n = (len < lvl) ? len : lvl;
    if ((op == 2 || op == 3) && n < len) clamp_m = 1'b1;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    if (op == 1) begin
      #1;
      chk("load_ctrl", int'(sr_ctrl_code), 1);
      chk("load_busy", int'(busy), 1);
      chk("load_cmd_ready", int'(cmd_ready), 0);
      @(posedge clk); @(negedge clk);
      lvl = LEN;
      exp_q.delete();
      for (int i = 0; i < LEN; i++) exp_q.push_back(load_vals[i]);
    end else if (op >= 2 && n > 0) begin
      cnt = 0;
      cyc = 0;
      while (cnt < n) begin
        if (abort == cnt) begin
          reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; cmd_valid = 1'b0;
          @(posedge clk); @(negedge clk);
          reset = 1'b0;
          #1;
          check_reset_outputs("abort");
          lvl = 0; clamp_m = 1'b0; exp_q.delete();
          return;
        end
        if (cyc > 300) begin
          chk("handshake_timeout", cyc, 300);
          break;
        end
        want = use_pat ? ((cyc < 8) ? pat[cyc] : 1'b1) : ($urandom_range(0, 99) < vpct);
        cmd_valid = 1'($urandom_range(0, 1));
        cmd_op    = 2'($urandom_range(0, 3));
        cmd_len   = LW'($urandom_range(0, 7));
        if (op == 2) begin
          in_valid = want;
          in_data  = use_pat ? DW'(5 + cnt) : DW'($urandom);
        end else begin
          out_ready = want;
        end
        #1;
        chk("busy_active", int'(busy), 1);
        chk("no_cmd_while_busy", int'(cmd_ready), 0);
        chk("done_mid", int'(done), 0);
        chk("level_mid", int'(level), lvl);
        if (op == 2) begin
          chk("in_ready", int'(in_ready), 1);
          chk("out_valid_in_write", int'(out_valid), 0);
          chk("write_ctrl", int'(sr_ctrl_code), want ? 2 : 0);
          if (want) begin
            exp_q.push_back(in_data);
            lvl++; cnt++;
          end
        end else begin
          chk("out_valid", int'(out_valid), 1);
          chk("in_ready_in_drain", int'(in_ready), 0);
          chk("drain_ctrl", int'(sr_ctrl_code), want ? 3 : 0);
          chk("out_data", int'(out_data), (exp_q.size() > 0) ? int'(exp_q[0]) : -1);
          if (want) begin
            if (exp_q.size() > 0) void'(exp_q.pop_front());
            lvl--; cnt++;
          end
        end
        @(posedge clk); @(negedge clk);
        cyc++;
      end
      in_valid = 1'b0; out_ready = 1'b0; cmd_valid = 1'b0;
    end
    #1;
    chk("done_pulse", int'(done), 1);
    chk("busy_after", int'(busy), 0);
    chk("ctrl_idle", int'(sr_ctrl_code), 0);
    chk("level_after", int'(level), lvl);
    chk("clamp_err", int'(clamp_err), int'(clamp_m));
    @(posedge clk); @(negedge clk);
    #1;
    chk("done_one_cycle", int'(done), 0);
  endtask

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_len = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    lvl = 0; clamp_m = 1'b0;
    for (int i = 0; i < LEN; i++) load_vals[i] = DW'(i + 1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    do_cmd(1, 0, 1'b1, 8'hFF, 100, -1);          // LOAD 1,2,3,4
    do_cmd(3, 4, 1'b1, 8'hFF, 100, -1);          // DRAIN 1..4 back to back
    do_cmd(2, 3, 1'b1, 8'b0000_1101, 100, -1);   // WRITE 5,6,7 with a gap
    do_cmd(3, 3, 1'b1, 8'hFF, 100, -1);
    do_cmd(2, 3, 1'b1, 8'hFF, 100, -1);
    do_cmd(3, 3, 1'b1, 8'b0001_1001, 100, -1);   // DRAIN with stalls
    do_cmd(2, 1, 1'b1, 8'hFF, 100, -1);
    do_cmd(3, 4, 1'b1, 8'hFF, 100, -1);          // clamped to one word
    do_cmd(1, 0, 1'b1, 8'hFF, 100, -1);
    do_cmd(2, 2, 1'b1, 8'hFF, 100, -1);          // full: clamped to nothing
    do_cmd(0, 3, 1'b1, 8'hFF, 100, -1);          // NOP
    do_cmd(3, 0, 1'b1, 8'hFF, 100, -1);          // zero length
    do_cmd(3, 4, 1'b1, 8'hFF, 100, 2);           // reset after two words

    repeat (80) begin
      int op, len, vp;
      op  = $urandom_range(0, 3);
      len = $urandom_range(0, 7);
      vp  = $urandom_range(30, 100);
      for (int i = 0; i < LEN; i++) load_vals[i] = DW'($urandom);
      do_cmd(op, len, 1'b0, 8'h00, vp, -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
